// File: rtl/multicycle_ctrl_if.sv
// Control bundle between run control, the instruction/data memories, the
// datapath and the multi-cycle sequencer. The sequencer uses the master view.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             run_i;
  logic [6:0]       opcode_i;
  logic             imem_req_o;
  logic             imem_ack_i;
  logic             dmem_req_o;
  logic             dmem_we_o;
  logic             dmem_ack_i;
  logic             ir_wr_o;
  logic             pc_wr_o;
  logic             reg_wr_o;
  logic             alusrc_o;
  logic             memtoreg_o;
  logic [1:0]       aluop_o;
  logic             busy_o;
  logic             trap_o;
  logic [1:0]       trap_cause_o;
  logic [CNT_W-1:0] retired_o;

  modport master (
    input  run_i, opcode_i, imem_ack_i, dmem_ack_i,
    output imem_req_o, dmem_req_o, dmem_we_o, ir_wr_o, pc_wr_o, reg_wr_o,
           alusrc_o, memtoreg_o, aluop_o, busy_o, trap_o, trap_cause_o,
           retired_o
  );

  modport slave (
    output run_i, opcode_i, imem_ack_i, dmem_ack_i,
    input  imem_req_o, dmem_req_o, dmem_we_o, ir_wr_o, pc_wr_o, reg_wr_o,
           alusrc_o, memtoreg_o, aluop_o, busy_o, trap_o, trap_cause_o,
           retired_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the RV32 subset core (ADD/AND/OR, OP-IMM, LW, SW).
// Walks the shared datapath through FETCH/DECODE/EXEC/MEM/WB, runs the memory
// handshakes, counts retired instructions and traps on illegal opcodes or on
// a memory request that waits too long for its ack.
module multicycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  multicycle_ctrl_if.master bus
);

  // Watchdog only ever holds 0..TIMEOUT-1; keep at least one bit when disabled.
  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP
  } state_e;

  state_e           state_q, state_d;
  logic [6:0]       opc_q, opc_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             trap_q, trap_d;
  logic [1:0]       cause_q, cause_d;

  logic is_r, is_imm, is_lw, is_sw, opc_legal, wd_expire;

  assign is_r   = (opc_q == OP_R);
  assign is_imm = (opc_q == OP_IMM);
  assign is_lw  = (opc_q == OP_LW);
  assign is_sw  = (opc_q == OP_SW);

  // Legality is judged on the live IR in DECODE, before the latch updates.
  assign opc_legal = (bus.opcode_i == OP_R)  || (bus.opcode_i == OP_IMM) ||
                     (bus.opcode_i == OP_LW) || (bus.opcode_i == OP_SW);

  // Fires in the TIMEOUT-th consecutive un-acked request cycle.
  assign wd_expire = (TIMEOUT != 0) && (wd_q == WD_W'(TIMEOUT - 1));

  // Next-state, watchdog, retire counter and trap bookkeeping.
  always_comb begin
    state_d   = state_q;
    opc_d     = opc_q;
    wd_d      = '0;
    retired_d = retired_q;
    trap_d    = trap_q;
    cause_d   = cause_q;
    case (state_q)
      IDLE: begin
        if (bus.run_i) state_d = FETCH;
      end
      FETCH: begin
        if (bus.imem_ack_i) begin
          state_d = DECODE;
        end else if (wd_expire) begin
          state_d = TRAP;
          trap_d  = 1'b1;
          cause_d = 2'b10;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      DECODE: begin
        opc_d = bus.opcode_i;
        if (opc_legal) begin
          state_d = EXEC;
        end else begin
          state_d = TRAP;
          trap_d  = 1'b1;
          cause_d = 2'b01;
        end
      end
      EXEC: begin
        state_d = (is_lw || is_sw) ? MEM : WB;
      end
      MEM: begin
        if (bus.dmem_ack_i) begin
          if (is_sw) begin
            retired_d = retired_q + CNT_W'(1);
            state_d   = bus.run_i ? FETCH : IDLE;
          end else begin
            state_d = WB;
          end
        end else if (wd_expire) begin
          state_d = TRAP;
          trap_d  = 1'b1;
          cause_d = 2'b11;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      WB: begin
        retired_d = retired_q + CNT_W'(1);
        state_d   = bus.run_i ? FETCH : IDLE;
      end
      TRAP: begin
        state_d = TRAP;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer state register; reset parks in IDLE and clears all history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      opc_q     <= '0;
      wd_q      <= '0;
      retired_q <= '0;
      trap_q    <= 1'b0;
      cause_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      wd_q      <= wd_d;
      retired_q <= retired_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
    end
  end

  // Strobes and selects decoded from the current state, latched opcode and acks.
  assign bus.imem_req_o   = (state_q == FETCH);
  assign bus.ir_wr_o      = (state_q == FETCH) && bus.imem_ack_i;
  assign bus.dmem_req_o   = (state_q == MEM);
  assign bus.dmem_we_o    = (state_q == MEM) && is_sw;
  assign bus.alusrc_o     = ((state_q == EXEC) && !is_r) || (state_q == MEM);
  assign bus.aluop_o      = ((state_q == EXEC) && (is_r || is_imm)) ? 2'b10 : 2'b00;
  assign bus.memtoreg_o   = (state_q == WB) && is_lw;
  assign bus.reg_wr_o     = (state_q == WB);
  assign bus.pc_wr_o      = (state_q == WB) ||
                            ((state_q == MEM) && is_sw && bus.dmem_ack_i);
  assign bus.busy_o       = (state_q != IDLE) && (state_q != TRAP);
  assign bus.trap_o       = trap_q;
  assign bus.trap_cause_o = cause_q;
  assign bus.retired_o    = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a per-cycle vector table for a normal
// instruction stream, then hand-written sequences for reset, traps, watchdog
// boundaries and retired-counter wrap.
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_ADDI = 7'h13;
  localparam logic [6:0] OP_ADD  = 7'h33;
  localparam logic [6:0] OP_LW   = 7'h03;
  localparam logic [6:0] OP_SW   = 7'h23;
  localparam logic [6:0] OP_BAD  = 7'h7F;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  multicycle_ctrl_if #(.CNT_W(4)) bus ();

  multicycle_ctrl #(.TIMEOUT(16), .CNT_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Observed outputs packed as {strobes[7:0], aluop, busy, trap, cause, retired}
  // with strobes = {imem_req, dmem_req, dmem_we, ir_wr, pc_wr, reg_wr, alusrc, memtoreg}.
  logic [17:0] actVec;
  assign actVec = {bus.imem_req_o, bus.dmem_req_o, bus.dmem_we_o, bus.ir_wr_o,
                   bus.pc_wr_o, bus.reg_wr_o, bus.alusrc_o, bus.memtoreg_o,
                   bus.aluop_o, bus.busy_o, bus.trap_o, bus.trap_cause_o,
                   bus.retired_o};

  typedef struct {
    logic        run;
    logic [6:0]  opc;
    logic        iack;
    logic        dack;
    logic [17:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Builds an expected output vector from hand-computed fields.
  function automatic logic [17:0] mk(input logic [7:0] strobes, input logic [1:0] aop,
                                     input logic bsy, input logic trp,
                                     input logic [1:0] cause, input logic [3:0] ret);
    return {strobes, aop, bsy, trp, cause, ret};
  endfunction

  task automatic addVec(input logic run, input logic [6:0] opc, input logic iack,
                        input logic dack, input logic [17:0] exp);
    vec_t v;
    v.run = run; v.opc = opc; v.iack = iack; v.dack = dack; v.exp = exp;
    vecs.push_back(v);
  endtask

  // Drives inputs just after a rising edge, then waits for the falling edge to sample.
  task automatic applyStimulus(input logic run, input logic [6:0] opc,
                               input logic iack, input logic dack);
    bus.run_i      = run;
    bus.opcode_i   = opc;
    bus.imem_ack_i = iack;
    bus.dmem_ack_i = dack;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [17:0] exp);
    checks++;
    if (actVec !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %b required %b", name, actVec, exp);
    end
  endtask

  task automatic checkRetired(input string name, input logic [3:0] exp);
    checks++;
    if (bus.retired_o !== exp) begin
      failures++;
      $display("[TB] FAIL %s: retired got %0d required %0d", name, bus.retired_o, exp);
    end
  endtask

  task automatic doReset();
    rst_n          = 1'b0;
    bus.run_i      = 1'b0;
    bus.opcode_i   = '0;
    bus.imem_ack_i = 1'b0;
    bus.dmem_ack_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Hard stop in case something leaves the bench waiting forever.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish required finish");
    $fatal(1, "[TB] timeout");
  end

  // Main stimulus: table first, then the multi-cycle corner sequences.
  initial begin
    // ADDI, zero-wait fetch: IDLE, FETCH(ir_wr), DECODE, EXEC, WB
    addVec(0, OP_ADDI, 0, 0, mk(8'b0000_0000, 2'b00, 0, 0, 2'b00, 4'd0));
    addVec(1, OP_ADDI, 0, 0, mk(8'b0000_0000, 2'b00, 0, 0, 2'b00, 4'd0));
    addVec(1, OP_ADDI, 1, 0, mk(8'b1001_0000, 2'b00, 1, 0, 2'b00, 4'd0));
    addVec(1, OP_ADDI, 0, 0, mk(8'b0000_0000, 2'b00, 1, 0, 2'b00, 4'd0));
    addVec(1, OP_ADDI, 0, 0, mk(8'b0000_0010, 2'b10, 1, 0, 2'b00, 4'd0));
    addVec(1, OP_ADDI, 0, 0, mk(8'b0000_1100, 2'b00, 1, 0, 2'b00, 4'd0));
    // ADD with one fetch wait cycle
    addVec(1, OP_ADD, 0, 0, mk(8'b1000_0000, 2'b00, 1, 0, 2'b00, 4'd1));
    addVec(1, OP_ADD, 1, 0, mk(8'b1001_0000, 2'b00, 1, 0, 2'b00, 4'd1));
    addVec(1, OP_ADD, 0, 0, mk(8'b0000_0000, 2'b00, 1, 0, 2'b00, 4'd1));
    addVec(1, OP_ADD, 0, 0, mk(8'b0000_0000, 2'b10, 1, 0, 2'b00, 4'd1));
    addVec(1, OP_ADD, 0, 0, mk(8'b0000_1100, 2'b00, 1, 0, 2'b00, 4'd1));
    // SW zero-wait: pc_wr in the dmem ack cycle, no reg_wr
    addVec(1, OP_SW, 1, 0, mk(8'b1001_0000, 2'b00, 1, 0, 2'b00, 4'd2));
    addVec(1, OP_SW, 0, 0, mk(8'b0000_0000, 2'b00, 1, 0, 2'b00, 4'd2));
    addVec(1, OP_SW, 0, 0, mk(8'b0000_0010, 2'b00, 1, 0, 2'b00, 4'd2));
    addVec(1, OP_SW, 0, 1, mk(8'b0110_1010, 2'b00, 1, 0, 2'b00, 4'd2));
    // LW with dmem ack three cycles late, run dropped mid-instruction
    addVec(1, OP_LW, 1, 0, mk(8'b1001_0000, 2'b00, 1, 0, 2'b00, 4'd3));
    addVec(1, OP_LW, 0, 1, mk(8'b0000_0000, 2'b00, 1, 0, 2'b00, 4'd3));
    addVec(1, OP_LW, 0, 0, mk(8'b0000_0010, 2'b00, 1, 0, 2'b00, 4'd3));
    addVec(1, OP_LW, 0, 0, mk(8'b0100_0010, 2'b00, 1, 0, 2'b00, 4'd3));
    addVec(1, OP_LW, 0, 0, mk(8'b0100_0010, 2'b00, 1, 0, 2'b00, 4'd3));
    addVec(1, OP_LW, 0, 0, mk(8'b0100_0010, 2'b00, 1, 0, 2'b00, 4'd3));
    addVec(0, OP_LW, 0, 1, mk(8'b0100_0010, 2'b00, 1, 0, 2'b00, 4'd3));
    addVec(0, OP_LW, 0, 0, mk(8'b0000_1101, 2'b00, 1, 0, 2'b00, 4'd3));
    // Parked in IDLE; stray acks are ignored
    addVec(0, OP_LW, 1, 1, mk(8'b0000_0000, 2'b00, 0, 0, 2'b00, 4'd4));
    addVec(0, OP_LW, 1, 1, mk(8'b0000_0000, 2'b00, 0, 0, 2'b00, 4'd4));

    doReset();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].run, vecs[i].opc, vecs[i].iack, vecs[i].dack);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
      tick();
    end

    // Async reset in the middle of a load's MEM wait
    applyStimulus(1, OP_LW, 0, 0); tick();
    applyStimulus(1, OP_LW, 1, 0); tick();
    applyStimulus(1, OP_LW, 0, 0); tick();
    applyStimulus(1, OP_LW, 0, 0); tick();
    applyStimulus(1, OP_LW, 0, 0);
    checkOutput("t1_mem", mk(8'b0100_0010, 2'b00, 1, 0, 2'b00, 4'd4));
    bus.dmem_ack_i = 1'b1;
    rst_n = 1'b0;
    #1;
    checkOutput("t1_reset_now", mk(8'b0000_0000, 2'b00, 0, 0, 2'b00, 4'd0));
    tick();
    rst_n = 1'b1;
    applyStimulus(0, OP_LW, 0, 1);
    checkOutput("t1_after_release", mk(8'b0000_0000, 2'b00, 0, 0, 2'b00, 4'd0));
    tick();
    applyStimulus(0, OP_LW, 0, 1);
    checkRetired("t1_retired", 4'd0);
    tick();

    // Illegal opcode traps from DECODE and stays trapped whatever run does
    applyStimulus(1, OP_BAD, 0, 0);
    checkOutput("t5_idle", mk(8'b0000_0000, 2'b00, 0, 0, 2'b00, 4'd0));
    tick();
    applyStimulus(1, OP_BAD, 1, 0);
    checkOutput("t5_fetch", mk(8'b1001_0000, 2'b00, 1, 0, 2'b00, 4'd0));
    tick();
    applyStimulus(1, OP_BAD, 0, 0);
    checkOutput("t5_decode", mk(8'b0000_0000, 2'b00, 1, 0, 2'b00, 4'd0));
    tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(i[0], OP_BAD, 1, 1);
      checkOutput($sformatf("t5_trap%0d", i), mk(8'b0000_0000, 2'b00, 0, 1, 2'b01, 4'd0));
      tick();
    end
    doReset();

    // Fetch watchdog: 16 un-acked request cycles, then trap cause 10
    applyStimulus(1, OP_ADDI, 0, 0); tick();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, OP_ADDI, 0, 0);
      checkOutput($sformatf("t6_wait%0d", i), mk(8'b1000_0000, 2'b00, 1, 0, 2'b00, 4'd0));
      tick();
    end
    applyStimulus(1, OP_ADDI, 1, 0);
    checkOutput("t6_trap", mk(8'b0000_0000, 2'b00, 0, 1, 2'b10, 4'd0));
    tick();
    doReset();

    // Fetch ack arriving in the 16th request cycle still wins over the watchdog
    applyStimulus(1, OP_ADDI, 0, 0); tick();
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1, OP_ADDI, 0, 0);
      checkOutput($sformatf("t6b_wait%0d", i), mk(8'b1000_0000, 2'b00, 1, 0, 2'b00, 4'd0));
      tick();
    end
    applyStimulus(1, OP_ADDI, 1, 0);
    checkOutput("t6b_ack16", mk(8'b1001_0000, 2'b00, 1, 0, 2'b00, 4'd0));
    tick();
    applyStimulus(1, OP_ADDI, 0, 0);
    checkOutput("t6b_decode", mk(8'b0000_0000, 2'b00, 1, 0, 2'b00, 4'd0));
    tick();
    doReset();

    // Data watchdog on a store: trap cause 11, request drops
    applyStimulus(1, OP_SW, 0, 0); tick();
    applyStimulus(1, OP_SW, 1, 0); tick();
    applyStimulus(1, OP_SW, 0, 0); tick();
    applyStimulus(1, OP_SW, 0, 0); tick();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, OP_SW, 0, 0);
      checkOutput($sformatf("dmem_wait%0d", i), mk(8'b0110_0010, 2'b00, 1, 0, 2'b00, 4'd0));
      tick();
    end
    applyStimulus(1, OP_SW, 0, 1);
    checkOutput("dmem_trap", mk(8'b0000_0000, 2'b00, 0, 1, 2'b11, 4'd0));
    tick();
    doReset();

    // Sixteen back-to-back ADDIs wrap the 4-bit retired counter to zero
    applyStimulus(1, OP_ADDI, 0, 0); tick();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, OP_ADDI, 1, 0); tick();
      applyStimulus(1, OP_ADDI, 0, 0); tick();
      applyStimulus(1, OP_ADDI, 0, 0); tick();
      applyStimulus((i != 15), OP_ADDI, 0, 0);
      checkOutput($sformatf("wrap_wb%0d", i), mk(8'b0000_1100, 2'b00, 1, 0, 2'b00, 4'(i)));
      tick();
    end
    applyStimulus(0, OP_ADDI, 0, 0);
    checkOutput("wrap_idle", mk(8'b0000_0000, 2'b00, 0, 0, 2'b00, 4'd0));
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
